// File: rtl/arb2_ctrl.sv
// Purpose: two-requester arbiter for the shared y/z datapath; A has static priority, B is forced in after STARVE A wins.
// Latency: a request sampled in IDLE is granted after the next edge; each grant is followed by a RELEASE cycle and an IDLE cycle.
// Backpressure: no preemption; the owner holds until done, until its request drops, or until the TIMEOUT hold limit.
module arb2_ctrl #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned STARVE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       done,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_A   = 2'd1,
        OWN_B   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE);
    localparam logic [7:0] HOLD_LAST  = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
    logic       owner_req;

    // Next-state, counter and timeout-pulse computation.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = 1'b0;
        owner_req    = 1'b0;
        case (state_q)
            IDLE: begin
                // Hold counter is zeroed here so it reads 0 in the first owned cycle.
                hold_cnt_d = 8'd0;
                if (req_a && (!req_b || starve_cnt_q < STARVE_MAX)) begin
                    state_d = OWN_A;
                    // Only A wins that made B wait count toward starvation.
                    if (req_b && starve_cnt_q < STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (req_b) begin
                    state_d      = OWN_B;
                    starve_cnt_d = 4'd0;
                end
            end
            OWN_A, OWN_B: begin
                owner_req  = (state_q == OWN_A) ? req_a : req_b;
                hold_cnt_d = hold_cnt_q + 8'd1;
                // A normal release wins over the hold limit, so no timeout pulse then.
                if (done || !owner_req) begin
                    state_d = RELEASE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset drops any grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            hold_cnt_q   <= 8'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free and never 11.
    always_comb begin
        gnt     = 2'b00;
        busy    = (state_q != IDLE);
        timeout = timeout_q;
        if (state_q == OWN_A) begin
            gnt = 2'b01;
        end else if (state_q == OWN_B) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: tb/tb_arb2_ctrl.sv
// Directed bench for arb2_ctrl with default TIMEOUT=8, STARVE=2.
// Observed vector is {gnt, busy, timeout}: 0000 idle, 0110 A owns, 1010 B owns, 0010 release, 0011 release with timeout.
module tb_arb2_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, done;
    logic [1:0] gnt;
    logic       busy, timeout;

    int n_cmp = 0;
    int n_err = 0;
    int n_gnt11 = 0;

    arb2_ctrl #(.TIMEOUT(8), .STARVE(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gnt === 2'b11) n_gnt11++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_vec();
        return {4'b0000, gnt, busy, timeout};
    endfunction

    initial begin
        logic [1:0] exp_g;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done = 1'b0;
        #1;
        chk("reset_state", obs_vec(), 8'b0000_0000);
        step();
        rst = 1'b0;

        // A alone, done during the 3rd owned cycle.
        req_a = 1'b1;
        step(); chk("a_own1", obs_vec(), 8'b0000_0110);
        step(); chk("a_own2", obs_vec(), 8'b0000_0110);
        step(); chk("a_own3", obs_vec(), 8'b0000_0110);
        done = 1'b1;
        step(); chk("a_release", obs_vec(), 8'b0000_0010);
        done = 1'b0;
        step(); chk("a_gap_idle", obs_vec(), 8'b0000_0000);
        step(); chk("a_regrant", obs_vec(), 8'b0000_0110);
        req_a = 1'b0;
        step(); chk("a_drop_release", obs_vec(), 8'b0000_0010);
        step(); chk("a_drop_idle", obs_vec(), 8'b0000_0000);

        // Both held, done on every 2nd owned cycle: A, A, B, A, A, B.
        req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_g = (k == 2 || k == 5) ? 2'b10 : 2'b01;
            step(); chk($sformatf("fair%0d_own1", k), obs_vec(), {4'b0000, exp_g, 2'b10});
            step(); chk($sformatf("fair%0d_own2", k), obs_vec(), {4'b0000, exp_g, 2'b10});
            done = 1'b1;
            step(); chk($sformatf("fair%0d_release", k), obs_vec(), 8'b0000_0010);
            done = 1'b0;
            step(); chk($sformatf("fair%0d_idle", k), obs_vec(), 8'b0000_0000);
        end

        // B alone, no done: 8 owned cycles, timeout pulse in RELEASE.
        req_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(); chk($sformatf("b_hold%0d", k), obs_vec(), 8'b0000_1010);
        end
        step(); chk("b_timeout_pulse", obs_vec(), 8'b0000_0011);
        step(); chk("b_to_idle", obs_vec(), 8'b0000_0000);
        step(); chk("b_regrant", obs_vec(), 8'b0000_1010);

        // done coinciding with the last allowed hold cycle: plain release.
        for (int k = 1; k < 8; k++) begin
            step(); chk($sformatf("b2_hold%0d", k), obs_vec(), 8'b0000_1010);
        end
        done = 1'b1;
        step(); chk("done_at_limit_release", obs_vec(), 8'b0000_0010);
        done = 1'b0;
        step(); chk("done_at_limit_idle", obs_vec(), 8'b0000_0000);

        // A wins (starve count cleared by B), B waits without preempting, A drops.
        req_a = 1'b1;
        step(); chk("nopreempt_own1", obs_vec(), 8'b0000_0110);
        step(); chk("nopreempt_own2", obs_vec(), 8'b0000_0110);
        req_a = 1'b0;
        step(); chk("adrop_release", obs_vec(), 8'b0000_0010);
        step(); chk("adrop_idle", obs_vec(), 8'b0000_0000);
        step(); chk("adrop_b_grant", obs_vec(), 8'b0000_1010);
        req_b = 1'b0;
        step(); chk("b_drop_release", obs_vec(), 8'b0000_0010);

        // done in IDLE and RELEASE is ignored.
        done = 1'b1;
        step(); chk("done_idle_ignored", obs_vec(), 8'b0000_0000);
        step(); chk("done_idle_ignored2", obs_vec(), 8'b0000_0000);
        done = 1'b0;

        // Asynchronous reset mid-grant with req_a held.
        req_a = 1'b1;
        step(); chk("pre_reset_own", obs_vec(), 8'b0000_0110);
        step(); chk("pre_reset_own2", obs_vec(), 8'b0000_0110);
        rst = 1'b1;
        #1;
        chk("async_reset", obs_vec(), 8'b0000_0000);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_no_release", obs_vec(), 8'b0000_0000);
        step(); chk("post_reset_grant", obs_vec(), 8'b0000_0110);
        req_a = 1'b0;
        step(); chk("post_reset_release", obs_vec(), 8'b0000_0010);
        step();

        chk("gnt_never_11", 8'(n_gnt11), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
